// File: rtl/panda_hazard_id.sv
// panda_hazard_id: ID-stage hazard/stall controller, companion of the ID forward unit.
// Detects RAW hazards that EX/MEM->ID forwarding cannot cover (load-use, and
// branch/jalr operands still in ID/EX or loaded in EX/MEM), then holds IF/ID and
// injects ID/EX bubbles for a counted number of cycles.
// Optional feature macro: PANDA_HAZARD_PERF_EN enables the stall-cycle counter.

package panda_hazard_id_pkg;
   typedef enum logic [1:0] {
      RD_DATA_ALU  = 2'd0,
      RD_DATA_LOAD = 2'd1,
      RD_DATA_PC4  = 2'd2,
      RD_DATA_CSR  = 2'd3
   } rd_data_sel_e;
endpackage

module panda_hazard_id
   import panda_hazard_id_pkg::*;
#(
   parameter int unsigned BRANCH_LOAD_STALLS = 2,
   parameter int unsigned PERF_CNT_W         = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  id_valid_i,
   input  logic                  branch_i,
   input  logic                  jalr_i,
   input  logic                  rs1_used_i,
   input  logic                  rs2_used_i,
   input  logic [4:0]            rs1_addr_i,
   input  logic [4:0]            rs2_addr_i,
   input  logic [4:0]            id_ex_rd_addr_i,
   input  logic                  id_ex_rd_we_i,
   input  rd_data_sel_e          id_ex_rd_data_sel_i,
   input  logic [4:0]            ex_mem_rd_addr_i,
   input  logic                  ex_mem_rd_we_i,
   input  rd_data_sel_e          ex_mem_rd_data_sel_i,
   input  logic                  mem_stall_i,
   input  logic                  flush_i,
   output logic                  stall_if_o,
   output logic                  stall_id_o,
   output logic                  bubble_ex_o,
   output logic [PERF_CNT_W-1:0] perf_stall_cnt_o
);

   localparam int unsigned      CNT_W     = 2;
   localparam logic [CNT_W-1:0] CNT_IDLE  = 2'd0;
   localparam logic [CNT_W-1:0] CNT_ONE   = 2'd1;
   localparam logic [CNT_W-1:0] BR_LOAD_N = CNT_W'(BRANCH_LOAD_STALLS);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] need_n;
   logic             idle;
   logic             stall;
   logic             use1_ex;
   logic             use2_ex;
   logic             use1_mem;
   logic             use2_mem;
   logic             ex_load;
   logic             mem_load;
   logic             is_ctrl;
   logic             ctrl_ex;
   logic             ctrl_mem;

   // Operand match against the two producer stages
   always_comb begin
      use1_ex  = rs1_used_i && id_ex_rd_we_i && (rs1_addr_i == id_ex_rd_addr_i)
                 && (rs1_addr_i != 5'd0);
      use2_ex  = rs2_used_i && id_ex_rd_we_i && (rs2_addr_i == id_ex_rd_addr_i)
                 && (rs2_addr_i != 5'd0);
      use1_mem = rs1_used_i && ex_mem_rd_we_i && (rs1_addr_i == ex_mem_rd_addr_i)
                 && (rs1_addr_i != 5'd0);
      use2_mem = rs2_used_i && ex_mem_rd_we_i && (rs2_addr_i == ex_mem_rd_addr_i)
                 && (rs2_addr_i != 5'd0);
      ex_load  = (id_ex_rd_data_sel_i == RD_DATA_LOAD);
      mem_load = (ex_mem_rd_data_sel_i == RD_DATA_LOAD);
      is_ctrl  = branch_i || jalr_i;
      // jalr resolves on rs1 only; branches compare both operands
      ctrl_ex  = (branch_i && (use1_ex || use2_ex)) || (jalr_i && use1_ex);
      ctrl_mem = (branch_i && (use1_mem || use2_mem)) || (jalr_i && use1_mem);
   end

   // Required stall length; the branch-on-load case is always the largest
   always_comb begin
      need_n = CNT_IDLE;
      if (id_valid_i && !flush_i) begin
         if (ex_load && ctrl_ex) begin
            need_n = BR_LOAD_N;
         end else if ((ex_load && (use1_ex || use2_ex) && !is_ctrl)
                      || (!ex_load && ctrl_ex)
                      || (mem_load && ctrl_mem)) begin
            need_n = CNT_ONE;
         end
      end
   end

   // Stall decode and next count; flush beats memory stall beats detection
   always_comb begin
      idle  = (cnt_q == CNT_IDLE);
      stall = !rst_i && !flush_i && !mem_stall_i && (!idle || (need_n != CNT_IDLE));
      cnt_d = cnt_q;
      if (flush_i) begin
         cnt_d = CNT_IDLE;
      end else if (mem_stall_i) begin
         cnt_d = cnt_q;
      end else if (!idle) begin
         cnt_d = cnt_q - CNT_ONE;
      end else if (need_n != CNT_IDLE) begin
         cnt_d = need_n - CNT_ONE;
      end
   end

   // Remaining-stall counter
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= CNT_IDLE;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign stall_if_o  = stall;
   assign stall_id_o  = stall;
   assign bubble_ex_o = stall;

`ifdef PANDA_HAZARD_PERF_EN
   logic [PERF_CNT_W-1:0] perf_q;

   // Hazard stall-cycle counter, wraps naturally
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_q <= '0;
      end else if (stall) begin
         perf_q <= perf_q + PERF_CNT_W'(1);
      end
   end

   assign perf_stall_cnt_o = perf_q;
`else
   assign perf_stall_cnt_o = '0;
`endif

endmodule
